// File: rtl/midi_tx_arbiter.sv
// midi_tx_arbiter: merges two MIDI byte streams (A = notes, B = volume) onto
// a single UART transmitter. Each source has its own byte FIFO, and whole
// 3-byte messages are sent atomically. The sources alternate round-robin
// from one message to the next.
// Optional build macro MIDI_RUNNING_STATUS_EN: a status byte that repeats
// the last transmitted status is suppressed, so that message is sent as
// 2 bytes.
module midi_tx_arbiter #(
  parameter int DEPTH   = 8,
  parameter int MSG_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a_byte,
  input  logic       a_send,
  output logic       a_ready,
  output logic       a_ovf,
  input  logic [7:0] b_byte,
  input  logic       b_send,
  output logic       b_ready,
  output logic       b_ovf,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] MSG_CNT  = CW'(MSG_LEN);
  localparam logic [1:0]    MSG_LAST = 2'(MSG_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_HOLD,
    S_WAIT
  } state_t;

  state_t state_q, state_d;

  // Index 0 is source A and index 1 is source B throughout.
  logic [1:0][7:0] src_byte;
  logic [1:0][7:0] src_head;
  logic [1:0]      src_send;
  logic [1:0]      src_pop;
  logic [1:0]      src_elig;
  logic [1:0]      src_ready;
  logic [1:0]      src_ovf;

  assign src_byte = {b_byte, a_byte};
  assign src_send = {b_send, a_send};
  assign a_ready  = src_ready[0];
  assign b_ready  = src_ready[1];
  assign a_ovf    = src_ovf[0];
  assign b_ovf    = src_ovf[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [7:0]    mem_q [DEPTH];
      logic [AW-1:0] wr_ptr_q;
      logic [AW-1:0] rd_ptr_q;
      logic [CW-1:0] cnt_q;
      logic          ovf_q;
      logic          push;

      // A byte that arrives while the FIFO is full is dropped. It is never written.
      assign push = src_send[gi] && (cnt_q != FULL_CNT);

      // Byte storage. The pointers wrap naturally because DEPTH is a power of two.
      always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= src_byte[gi];
      end

      // Pointer, occupancy and overflow-pulse bookkeeping
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          cnt_q    <= '0;
          ovf_q    <= 1'b0;
        end else begin
          if (push)        wr_ptr_q <= wr_ptr_q + 1'b1;
          if (src_pop[gi]) rd_ptr_q <= rd_ptr_q + 1'b1;
          if (push && !src_pop[gi])      cnt_q <= cnt_q + 1'b1;
          else if (!push && src_pop[gi]) cnt_q <= cnt_q - 1'b1;
          ovf_q <= src_send[gi] && (cnt_q == FULL_CNT);
        end
      end

      assign src_head[gi]  = mem_q[rd_ptr_q];
      assign src_elig[gi]  = (cnt_q >= MSG_CNT);
      assign src_ready[gi] = (cnt_q != FULL_CNT);
      assign src_ovf[gi]   = ovf_q;
    end
  endgenerate

  logic       grant_q;
  logic       rr_ptr_q;
  logic       grant_sel;
  logic [1:0] byte_cnt_q;
  logic [7:0] tx_data_q;
  logic       tx_start_q;
  logic [7:0] cur_head;
  logic       skip_status;
  logic       issue_fire;
  logic       msg_done;

  assign cur_head = src_head[grant_q];
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;

  // If both sources are eligible, the round-robin pointer decides. Otherwise the one eligible source wins.
  assign grant_sel = (src_elig[0] && src_elig[1]) ? rr_ptr_q : !src_elig[0];

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] last_status_q;
  logic       last_valid_q;

  assign skip_status = last_valid_q && (cur_head == last_status_q);

  // Remember the most recent status byte that actually went to the UART
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_status_q <= 8'h00;
      last_valid_q  <= 1'b0;
    end else if (issue_fire && cur_head[7]) begin
      last_status_q <= cur_head;
      last_valid_q  <= 1'b1;
    end
  end
`else
  assign skip_status = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic for message sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (|src_elig) state_d = S_CHECK;
      S_CHECK: state_d = cur_head[7] ? S_ISSUE : S_IDLE;
      S_ISSUE: if (!tx_busy) state_d = S_HOLD;
      S_HOLD:  state_d = S_WAIT;
      S_WAIT:  if (!tx_busy) state_d = (byte_cnt_q < MSG_LAST) ? S_ISSUE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Per-state strobes: FIFO pops, byte issue and end of message
  always_comb begin
    src_pop    = '0;
    issue_fire = 1'b0;
    msg_done   = 1'b0;
    case (state_q)
      // An orphan data byte is dropped to resynchronise. A repeated status byte is dropped under running status.
      S_CHECK: if (!cur_head[7] || skip_status) src_pop[grant_q] = 1'b1;
      S_ISSUE: if (!tx_busy) begin
        issue_fire       = 1'b1;
        src_pop[grant_q] = 1'b1;
      end
      S_WAIT:  if (!tx_busy && (byte_cnt_q >= MSG_LAST)) msg_done = 1'b1;
      default: ;
    endcase
  end

  // Grant, round-robin pointer, byte counter and UART-facing registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q    <= 1'b0;
      rr_ptr_q   <= 1'b0;
      byte_cnt_q <= 2'd0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
    end else begin
      tx_start_q <= issue_fire;
      if (state_q == S_IDLE && |src_elig) grant_q <= grant_sel;
      if (state_q == S_CHECK && cur_head[7]) byte_cnt_q <= skip_status ? 2'd1 : 2'd0;
      if (issue_fire) begin
        tx_data_q  <= cur_head;
        byte_cnt_q <= byte_cnt_q + 2'd1;
      end
      if (msg_done) rr_ptr_q <= ~grant_q;
    end
  end

endmodule

// File: tb/tb_midi_tx_arbiter.sv
// Testbench for midi_tx_arbiter: directed scenarios plus a randomized
// two-source run scored against a message-level reference model.
module tb_midi_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] a_byte = 8'h00;
  logic       a_send = 1'b0;
  logic       a_ready;
  logic       a_ovf;
  logic [7:0] b_byte = 8'h00;
  logic       b_send = 1'b0;
  logic       b_ready;
  logic       b_ovf;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy = 1'b0;

  midi_tx_arbiter #(.DEPTH(8), .MSG_LEN(3)) dut (
    .clk(clk), .rst(rst),
    .a_byte(a_byte), .a_send(a_send), .a_ready(a_ready), .a_ovf(a_ovf),
    .b_byte(b_byte), .b_send(b_send), .b_ready(b_ready), .b_ovf(b_ovf),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] tx_log [$];
  logic [7:0] exp_q  [$];
  logic [7:0] stim_a [$];
  logic [7:0] stim_b [$];
  logic [7:0] exp_ra [$];
  logic [7:0] exp_rb [$];

  int busy_len   = 10;
  bit busy_rand  = 1'b0;
  bit force_busy = 1'b0;
  int busy_left  = 0;
  int ovf_a_cnt  = 0;
  int ovf_b_cnt  = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // UART model and output monitor
  initial begin
    forever begin
      @(posedge clk); #1;
      if (tx_start) begin
        tx_log.push_back(tx_data);
        busy_left = busy_rand ? int'($urandom_range(1, 6)) : busy_len;
      end else if (busy_left > 0) begin
        busy_left--;
      end
      if (a_ovf) ovf_a_cnt++;
      if (b_ovf) ovf_b_cnt++;
      tx_busy = force_busy || (busy_left > 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; a_send = 1'b0; b_send = 1'b0; force_busy = 1'b0; busy_rand = 1'b0;
    repeat (12) cycle();
    rst = 1'b1;
    tx_log.delete();
    ovf_a_cnt = 0;
    ovf_b_cnt = 0;
  endtask

  task automatic drive_a(input logic [7:0] b);
    a_byte = b; a_send = 1'b1;
    cycle();
    a_send = 1'b0;
  endtask

  task automatic drive_b(input logic [7:0] b);
    b_byte = b; b_send = 1'b1;
    cycle();
    b_send = 1'b0;
  endtask

  task automatic drive_pair(input logic [7:0] ba, input logic [7:0] bb);
    a_byte = ba; a_send = 1'b1; b_byte = bb; b_send = 1'b1;
    cycle();
    a_send = 1'b0; b_send = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    int c = 0;
    while (tx_log.size() < n && c < budget) begin
      cycle();
      c++;
    end
    if (tx_log.size() < n) check_value({tag, "_timeout"}, tx_log.size(), n);
  endtask

  task automatic expect_log(input string tag, input int settle);
    wait_log(exp_q.size(), 2000, tag);
    repeat (settle) cycle();
    check_value({tag, "_len"}, tx_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check_value($sformatf("%s_byte%0d", tag, i),
                  (i < tx_log.size()) ? {24'h0, tx_log[i]} : 32'hFFFF_FFFF, exp_q[i]);
    $display("txn %s: %0d bytes observed", tag, tx_log.size());
  endtask

  task automatic send_stream(input int src);
    int n = (src != 0) ? stim_b.size() : stim_a.size();
    for (int i = 0; i < n; i++) begin
      int c = 0;
      repeat ($urandom_range(0, 3)) cycle();
      while (!((src != 0) ? b_ready : a_ready) && c < 500) begin
        cycle();
        c++;
      end
      if (c >= 500) check_value("rand_ready_timeout", (src != 0) ? b_ready : a_ready, 1);
      if (src != 0) drive_b(stim_b[i]);
      else          drive_a(stim_a[i]);
    end
  endtask

  logic [7:0] ov_bytes [10];

  initial begin
    // Reset values while rst is held low
    repeat (3) cycle();
    check_value("rst_tx_start", tx_start, 0);
    check_value("rst_tx_data", tx_data, 8'h00);
    check_value("rst_a_ready", a_ready, 1);
    check_value("rst_b_ready", b_ready, 1);
    check_value("rst_a_ovf", a_ovf, 0);
    check_value("rst_b_ovf", b_ovf, 0);
    $display("txn reset: outputs checked");

    // Basic message, start latency N+3
    do_reset();
    busy_len = 10;
    drive_a(8'h90); drive_a(8'h3C); drive_a(8'h64);
    for (int k = 1; k <= 3; k++) begin
      cycle();
      check_value($sformatf("latency_edge%0d", k), tx_start, (k == 3) ? 1 : 0);
    end
    exp_q = '{8'h90, 8'h3C, 8'h64};
    expect_log("basic", 40);
    check_value("basic_a_ovf_count", ovf_a_cnt, 0);

    // Contention: both sources present at once, then a second pair queued mid-flight
    do_reset();
    drive_pair(8'h90, 8'hB0); drive_pair(8'h40, 8'h07); drive_pair(8'h7F, 8'h50);
    wait_log(1, 200, "contend_first");
    drive_pair(8'h91, 8'hB1); drive_pair(8'h41, 8'h08); drive_pair(8'h11, 8'h22);
    exp_q = '{8'h90, 8'h40, 8'h7F, 8'hB0, 8'h07, 8'h50,
              8'h91, 8'h41, 8'h11, 8'hB1, 8'h08, 8'h22};
    expect_log("contend", 40);

    // Resync: a leading orphan data byte is dropped
    do_reset();
    drive_b(8'h05); drive_b(8'hB0); drive_b(8'h07); drive_b(8'h40);
    exp_q = '{8'hB0, 8'h07, 8'h40};
    expect_log("resync", 40);

    // Overflow with the UART held busy
    do_reset();
    force_busy = 1'b1;
    ov_bytes = '{8'h90, 8'h01, 8'h02, 8'h91, 8'h03, 8'h04, 8'h92, 8'h05, 8'h93, 8'h06};
    for (int i = 0; i < 10; i++) begin
      drive_a(ov_bytes[i]);
      if (i == 6) check_value("ovf_ready_after7", a_ready, 1);
      if (i == 7) check_value("ovf_ready_after8", a_ready, 0);
      if (i == 8) check_value("ovf_pulse_byte9", a_ovf, 1);
    end
    cycle();
    check_value("ovf_pulse_end", a_ovf, 0);
    check_value("ovf_pulse_count", ovf_a_cnt, 2);
    busy_len = 3;
    force_busy = 1'b0;
    exp_q = '{8'h90, 8'h01, 8'h02, 8'h91, 8'h03, 8'h04};
    expect_log("overflow", 40);
    check_value("ovf_b_count", ovf_b_cnt, 0);

    // Reset in the middle of a message
    do_reset();
    busy_len = 10;
    drive_a(8'h90); drive_a(8'h3C); drive_a(8'h64); drive_a(8'hC0); drive_a(8'h05);
    wait_log(1, 200, "midrst_first");
    #2 rst = 1'b0;
    #1;
    check_value("midrst_tx_start", tx_start, 0);
    check_value("midrst_tx_data", tx_data, 8'h00);
    check_value("midrst_a_ready", a_ready, 1);
    check_value("midrst_b_ready", b_ready, 1);
    check_value("midrst_a_ovf", a_ovf, 0);
    check_value("midrst_b_ovf", b_ovf, 0);
    cycle();
    do_reset();
    drive_a(8'h90); drive_a(8'h11); drive_a(8'h22);
    exp_q = '{8'h90, 8'h11, 8'h22};
    expect_log("after_midrst", 40);

    // Running status: a repeated status byte is suppressed only when the feature is built in
    do_reset();
    drive_a(8'h90); drive_a(8'h3C); drive_a(8'h64);
    drive_a(8'h90); drive_a(8'h3E); drive_a(8'h64);
`ifdef MIDI_RUNNING_STATUS_EN
    exp_q = '{8'h90, 8'h3C, 8'h64, 8'h3E, 8'h64};
`else
    exp_q = '{8'h90, 8'h3C, 8'h64, 8'h90, 8'h3E, 8'h64};
`endif
    expect_log("running_status", 40);

    // Randomized run. Every status byte is distinct, so running status never triggers here.
    do_reset();
    busy_rand = 1'b1;
    stim_a.delete(); stim_b.delete(); exp_ra.delete(); exp_rb.delete();
    begin
      int off  = int'($urandom_range(0, 111));
      int gidx = 0;
      for (int src = 0; src < 2; src++) begin
        for (int m = 0; m < 8; m++) begin
          logic [7:0] st, d1, d2, orph;
          st   = 8'h80 + 8'((off + gidx * 5) % 112);
          gidx++;
          d1   = 8'($urandom_range(0, 127));
          d2   = 8'($urandom_range(0, 127));
          orph = 8'($urandom_range(0, 127));
          if (src == 0) begin
            if ($urandom_range(0, 3) == 0) stim_a.push_back(orph);
            stim_a.push_back(st); stim_a.push_back(d1); stim_a.push_back(d2);
            exp_ra.push_back(st); exp_ra.push_back(d1); exp_ra.push_back(d2);
          end else begin
            if ($urandom_range(0, 3) == 0) stim_b.push_back(orph);
            stim_b.push_back(st); stim_b.push_back(d1); stim_b.push_back(d2);
            exp_rb.push_back(st); exp_rb.push_back(d1); exp_rb.push_back(d2);
          end
        end
      end
    end
    fork
      send_stream(0);
      send_stream(1);
    join
    exp_q.delete();
    repeat (48) exp_q.push_back(8'h00);
    wait_log(48, 3000, "random");
    repeat (40) cycle();
    check_value("random_len", tx_log.size(), 48);
    for (int i = 0; i + 2 < tx_log.size(); i += 3) begin
      logic [7:0] st;
      st = tx_log[i];
      if (exp_ra.size() >= 3 && exp_ra[0] == st) begin
        for (int k = 0; k < 3; k++) begin
          check_value($sformatf("rand_a_msg%0d", i / 3), tx_log[i + k], exp_ra[0]);
          void'(exp_ra.pop_front());
        end
      end else if (exp_rb.size() >= 3 && exp_rb[0] == st) begin
        for (int k = 0; k < 3; k++) begin
          check_value($sformatf("rand_b_msg%0d", i / 3), tx_log[i + k], exp_rb[0]);
          void'(exp_rb.pop_front());
        end
      end else begin
        check_value($sformatf("rand_status%0d", i / 3), st,
                    (exp_ra.size() > 0) ? {24'h0, exp_ra[0]} : 32'hFFFF_FFFF);
      end
    end
    check_value("random_a_left", exp_ra.size(), 0);
    check_value("random_b_left", exp_rb.size(), 0);
    check_value("random_a_ovf", ovf_a_cnt, 0);
    check_value("random_b_ovf", ovf_b_cnt, 0);
    $display("txn random: %0d bytes observed", tx_log.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
